// File: rtl/vmul_result_queue.sv
// vmul_result_queue: in-order FWFT result FIFO behind the fixed-latency vector
// multiplier. It grants issue credits upstream so results always find space.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   issue_*        - upstream issue handshake; issue_ready means a credit is free
//   res_*          - multiplier result (valid, data, destination address)
//   wb_*           - register file write port (valid/ready, head data/address)
//   count          - FIFO occupancy
//   inflight       - issued operations whose results have not yet returned
//   err            - sticky protocol error flag
module vmul_result_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  wb_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  inflight,
  output logic                  err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_WIDTH + 1;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] infl_q, infl_d;
  logic                 err_q, err_d;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 iss;
  logic [SUM_W-1:0]     credits_used;

  // Outputs are forced to their idle values while rst is high so that a
  // mid-stream reset is visible in the same cycle, not one cycle later.
  assign credits_used = SUM_W'(count_q) + SUM_W'(infl_q);
  assign issue_ready  = !rst && (credits_used < SUM_W'(DEPTH));
  assign wb_valid     = !rst && (count_q != '0);
  assign count        = rst ? '0 : count_q;
  assign inflight     = rst ? '0 : infl_q;
  assign err          = rst ? 1'b0 : err_q;

  assign {wb_data, wb_addr} = mem_q[rd_ptr_q];

  assign full = (count_q == CNT_WIDTH'(DEPTH));
  assign pop  = wb_valid && wb_ready;
  assign push = !rst && res_valid && (!full || pop);
  assign iss  = issue_valid && issue_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    infl_d   = infl_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case (1'b1)
      push && !pop: count_d = count_q + CNT_WIDTH'(1);
      pop && !push: count_d = count_q - CNT_WIDTH'(1);
      default:      count_d = count_q;
    endcase

    // A result with no outstanding issue is unsolicited; the counter
    // saturates at zero instead of wrapping.
    unique case (1'b1)
      iss && !res_valid:                      infl_d = infl_q + CNT_WIDTH'(1);
      res_valid && !iss && (infl_q != '0):    infl_d = infl_q - CNT_WIDTH'(1);
      default:                                infl_d = infl_q;
    endcase

    if (res_valid && (infl_q == '0)) err_d = 1'b1;
    if (res_valid && !push)          err_d = 1'b1;
    if (issue_valid && !issue_ready) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately not reset; wb_valid qualifies the head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {res_data, res_addr};
  end

endmodule

// File: tb/tb_vmul_result_queue.sv
// tb_vmul_result_queue: directed-vector bench for vmul_result_queue.
// Inputs change just after posedge; outputs are sampled 1 time unit later.
module tb_vmul_result_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = '0;
  logic [31:0] res_addr = '0;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [31:0] wb_addr;
  logic        wb_ready = 1'b0;
  logic [3:0]  count;
  logic [3:0]  inflight;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  vmul_result_queue dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_addr   (res_addr),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_addr    (wb_addr),
    .wb_ready   (wb_ready),
    .count      (count),
    .inflight   (inflight),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to the next cycle; inputs may then be changed
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 1'b0;
    res_valid   = 1'b0;
    wb_ready    = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_in();
    for (int i = 0; i < n; i++) begin
      settle();
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      cyc();
    end
    rst = 1'b0;
    settle();
    chk("post_rst_issue_ready", 64'(issue_ready), 64'd1);
  endtask

  initial begin
    cyc();
    // reset: 3 cycles
    do_reset(3);

    // single result, 6-cycle multiplier latency
    issue_valid = 1'b1;
    settle();
    chk("s_iss_ready", 64'(issue_ready), 64'd1);
    cyc();
    issue_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      chk("s_inflight", 64'(inflight), 64'd1);
      chk("s_wb_idle", 64'(wb_valid), 64'd0);
      cyc();
    end
    res_valid = 1'b1;
    res_data  = 64'h0123456789ABCDEF;
    res_addr  = 32'h40;
    settle();
    chk("s_inflight6", 64'(inflight), 64'd1);
    chk("s_no_bypass", 64'(wb_valid), 64'd0);
    cyc();
    res_valid = 1'b0;
    wb_ready  = 1'b1;
    settle();
    chk("s_wb_valid7", 64'(wb_valid), 64'd1);
    chk("s_wb_data", wb_data, 64'h0123456789ABCDEF);
    chk("s_wb_addr", 64'(wb_addr), 64'h40);
    chk("s_inflight7", 64'(inflight), 64'd0);
    cyc();
    settle();
    chk("s_wb_valid8", 64'(wb_valid), 64'd0);
    chk("s_count8", 64'(count), 64'd0);
    chk("s_err", 64'(err), 64'd0);
    // empty FIFO with wb_ready high: no pop
    cyc();
    settle();
    chk("empty_count", 64'(count), 64'd0);
    wb_ready = 1'b0;

    // backpressure fill: 8 credits then stop
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1;
      settle();
      chk("f_iss_ready", 64'(issue_ready), 64'd1);
      cyc();
    end
    issue_valid = 1'b0;
    settle();
    chk("f_iss_blocked", 64'(issue_ready), 64'd0);
    chk("f_inflight8", 64'(inflight), 64'd8);
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1;
      res_data  = 64'(i);
      res_addr  = 32'(i * 8);
      cyc();
    end
    res_valid = 1'b0;
    settle();
    chk("f_count", 64'(count), 64'd8);
    chk("f_inflight0", 64'(inflight), 64'd0);
    chk("f_err", 64'(err), 64'd0);
    chk("f_ready_full", 64'(issue_ready), 64'd0);

    // pop one to free a credit
    wb_ready = 1'b1;
    settle();
    chk("p_head0", wb_data, 64'd0);
    cyc();
    wb_ready = 1'b0;
    settle();
    chk("p_count7", 64'(count), 64'd7);
    chk("p_credit", 64'(issue_ready), 64'd1);
    issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    settle();
    chk("p_inflight1", 64'(inflight), 64'd1);
    chk("p_no_credit", 64'(issue_ready), 64'd0);
    for (int c = 0; c < 5; c++) cyc();
    res_valid = 1'b1;
    res_data  = 64'd8;
    res_addr  = 32'd64;
    cyc();
    res_valid = 1'b0;
    settle();
    chk("p_refull", 64'(count), 64'd8);
    chk("p_inflight0", 64'(inflight), 64'd0);
    chk("p_err0", 64'(err), 64'd0);

    // full push+pop (unsolicited result, so err sets)
    res_valid = 1'b1;
    res_data  = 64'd9;
    res_addr  = 32'd72;
    wb_ready  = 1'b1;
    settle();
    chk("e_head1", wb_data, 64'd1);
    cyc();
    wb_ready = 1'b0;
    settle();
    chk("e_pp_count", 64'(count), 64'd8);
    chk("e_unsol_err", 64'(err), 64'd1);
    // full, no pop: dropped
    res_data = 64'hDEAD;
    res_addr = 32'hDEAD;
    cyc();
    res_valid = 1'b0;
    settle();
    chk("e_drop_count", 64'(count), 64'd8);
    chk("e_err_hold", 64'(err), 64'd1);

    // drain: 2..9 in order, one per cycle
    wb_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      settle();
      chk("d_valid", 64'(wb_valid), 64'd1);
      chk("d_data", wb_data, 64'(i));
      chk("d_addr", 64'(wb_addr), 64'(i * 8));
      cyc();
    end
    settle();
    chk("d_empty", 64'(wb_valid), 64'd0);
    chk("d_count", 64'(count), 64'd0);
    chk("d_err_sticky", 64'(err), 64'd1);
    wb_ready = 1'b0;
    cyc();

    // unsolicited into empty FIFO from clean state
    do_reset(1);
    res_valid = 1'b1;
    res_data  = 64'h55;
    res_addr  = 32'h5;
    cyc();
    res_valid = 1'b0;
    settle();
    chk("u_err", 64'(err), 64'd1);
    chk("u_count", 64'(count), 64'd1);
    chk("u_data", wb_data, 64'h55);
    chk("u_inflight", 64'(inflight), 64'd0);
    cyc();

    // reset mid-stream: 4 queued, 3 in flight
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      issue_valid = 1'b1;
      cyc();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_data  = 64'(100 + i);
      cyc();
    end
    res_valid = 1'b0;
    settle();
    chk("m_count4", 64'(count), 64'd4);
    chk("m_inflight3", 64'(inflight), 64'd3);
    do_reset(1);
    chk("m_count0", 64'(count), 64'd0);
    chk("m_inflight0", 64'(inflight), 64'd0);
    chk("m_wb_valid", 64'(wb_valid), 64'd0);
    chk("m_err", 64'(err), 64'd0);
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      settle();
      chk("m_no_stale", 64'(wb_valid), 64'd0);
    end
    wb_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
